// File: rtl/lda_arbiter.sv
// rtl/lda_arbiter.sv - two-requester arbiter and start/done sequencer for the LDA core
// Optional feature: define LDA_ARB_RR_EN for round-robin arbitration (default: requester 0 has fixed priority).
module lda_arbiter #(
    parameter int DONE_TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_valid,
    output logic [1:0]  o_ready,
    input  logic [36:0] i_cmd0,
    input  logic [36:0] i_cmd1,
    output logic [1:0]  o_done,
    output logic        o_error,
    output logic        o_busy,
    output logic [8:0]  o_x0,
    output logic [8:0]  o_x1,
    output logic [7:0]  o_y0,
    output logic [7:0]  o_y1,
    output logic [2:0]  o_color,
    output logic        o_start,
    input  logic        i_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam bit          WD_EN   = (DONE_TIMEOUT > 0);
    localparam logic [15:0] WD_LAST = WD_EN ? 16'(DONE_TIMEOUT - 1) : 16'd0;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_gnt;
    logic [15:0] r_wd_cnt;
    logic        w_gnt;
    logic        w_accept;
    logic        w_wd_hit;

    // w_gnt is only meaningful while at least one i_valid bit is set
`ifdef LDA_ARB_RR_EN
    assign w_gnt = (&i_valid) ? ~r_last : i_valid[1];
`else
    assign w_gnt = ~i_valid[0];
`endif

    assign w_accept = (r_state == S_IDLE) && (|i_valid) && !i_reset;
    assign o_ready  = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign w_wd_hit = WD_EN && (r_wd_cnt == WD_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|i_valid) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (i_done || w_wd_hit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_wd_cnt <= 16'd0;
            o_start  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 2'b00;
            o_error  <= 1'b0;
            o_x0     <= 9'd0;
            o_x1     <= 9'd0;
            o_y0     <= 8'd0;
            o_y1     <= 8'd0;
            o_color  <= 3'd0;
        end else begin
            r_state <= w_next;
            o_start <= (w_next == S_START);
            o_busy  <= (w_next != S_IDLE);
            o_done  <= 2'b00;
            o_error <= 1'b0;

            if (w_accept) begin
                r_gnt <= w_gnt;
                {o_x0, o_x1, o_y0, o_y1, o_color} <= w_gnt ? i_cmd1 : i_cmd0;
            end

            // counter is zero on the first WAIT cycle because it idles at zero elsewhere
            if (WD_EN && r_state == S_WAIT)
                r_wd_cnt <= r_wd_cnt + 16'd1;
            else
                r_wd_cnt <= 16'd0;

            // a real completion wins over a watchdog hit in the same cycle
            if (r_state == S_WAIT && w_next == S_DONE) begin
                o_done  <= r_gnt ? 2'b10 : 2'b01;
                o_error <= ~i_done;
            end

            if (r_state == S_DONE)
                r_last <= r_gnt;
        end
    end

endmodule

// File: tb/tb_lda_arbiter.sv
// tb/tb_lda_arbiter.sv - randomized scoreboard bench for lda_arbiter
module tb_lda_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  o_ready;
    logic [36:0] cmd0;
    logic [36:0] cmd1;
    logic [1:0]  o_done;
    logic        o_error;
    logic        o_busy;
    logic [8:0]  o_x0;
    logic [8:0]  o_x1;
    logic [7:0]  o_y0;
    logic [7:0]  o_y1;
    logic [2:0]  o_color;
    logic        o_start;
    logic        lda_done;

    lda_arbiter #(.DONE_TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (valid),
        .o_ready (o_ready),
        .i_cmd0  (cmd0),
        .i_cmd1  (cmd1),
        .o_done  (o_done),
        .o_error (o_error),
        .o_busy  (o_busy),
        .o_x0    (o_x0),
        .o_x1    (o_x1),
        .o_y0    (o_y0),
        .o_y1    (o_y1),
        .o_color (o_color),
        .o_start (o_start),
        .i_done  (lda_done)
    );

    typedef struct {
        int c;
        int g;
        bit err;
    } exp_t;

    exp_t        done_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_last = 1;
    bit          m_busy = 0;
    int          acc_cyc = -10;
    int          cur_g = 0;
    logic [36:0] cur_cmd = '0;
    bit          rst_seen = 0;
    bit          busy_pre;
    logic [1:0]  exp_rdy;
    int          mg;
    bit          stale_hold = 0;
    bit          rand_lat = 0;
    int          fixed_lat = 0;
    int          rs_s, rs_g, rs_lat;
    logic [1:0]  acc;
    int          n_acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [1:0] v, input int last);
`ifdef LDA_ARB_RR_EN
        if (v == 2'b11) return 1 - last;
`endif
        return v[0] ? 0 : 1;
    endfunction

    function automatic logic [36:0] rand_cmd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[36:0];
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, TO - 2));
        if (r == 7) return TO;
        if (r == 8) return TO + 1;
        return -1;
    endfunction

    // Monitor: reference model of accepts, start, hold, busy and done timing
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("ready_in_reset", o_ready, 2'b00);
            m_last = 1; m_busy = 0; cur_cmd = '0; acc_cyc = -10;
            done_q.delete();
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                chk("reset_outputs", {o_start, o_done, o_error, o_busy}, 5'd0);
                rst_seen = 0;
            end
            busy_pre = m_busy;
            chk("cmd_hold", {o_x0, o_x1, o_y0, o_y1, o_color}, cur_cmd);
            chk("busy", o_busy, busy_pre && cyc > acc_cyc);
            chk("start", o_start, busy_pre && cyc == acc_cyc + 1);
            if (done_q.size() > 0 && done_q[0].c == cyc) begin
                chk("done", o_done, (done_q[0].g == 1) ? 2'b10 : 2'b01);
                chk("error", o_error, done_q[0].err);
                m_last = done_q[0].g;
                m_busy = 0;
                void'(done_q.pop_front());
            end else begin
                chk("no_done", {o_done, o_error}, 3'd0);
            end
            exp_rdy = 2'b00;
            if (!busy_pre && valid != 2'b00) begin
                mg = model_grant(valid, m_last);
                exp_rdy = (mg == 1) ? 2'b10 : 2'b01;
                m_busy = 1; acc_cyc = cyc; cur_g = mg;
                cur_cmd = (mg == 1) ? cmd1 : cmd0;
            end
            chk("ready", o_ready, exp_rdy);
        end
    end

    // LDA responder: i_done after a chosen latency, or none (watchdog abort)
    initial begin
        lda_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && o_start) begin
                rs_s = cyc; rs_g = cur_g;
                rs_lat = rand_lat ? pick_lat() : fixed_lat;
                if (rs_lat < 0 || rs_lat >= TO)
                    done_q.push_back('{rs_s + 1 + TO, rs_g, 1'b1});
                for (int i = 0; i <= rs_lat; i++) begin
                    @(posedge clk); #1;
                    lda_done = (i == rs_lat);
                end
                if (rs_lat >= 0 && rs_lat < TO)
                    done_q.push_back('{cyc + 1, rs_g, 1'b0});
                @(posedge clk); #1;
                lda_done = 1'b0;
            end else begin
                @(posedge clk); #1;
                lda_done = stale_hold;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic request(input int k, input logic [36:0] c);
        bit got;
        got = 0;
        if (k == 0) cmd0 = c; else cmd1 = c;
        valid[k] = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = o_ready[k];
            step();
        end
        valid[k] = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL request_timeout: requester %0d got no ready within 100 cycles", k);
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((m_busy || done_q.size() != 0) && i < 300) begin
            step();
            i++;
        end
        checks++;
        if (m_busy || done_q.size() != 0) begin
            failures++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d expected 0 0", m_busy, done_q.size());
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 2'b00; cmd0 = '0; cmd1 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single request with the reference command
        fixed_lat = 6;
        request(0, {9'd10, 9'd200, 8'd5, 8'd100, 3'd3});
        wait_idle();

        // watchdog abort, then an immediate follow-up request
        fixed_lat = -1;
        request(0, rand_cmd());
        step();
        fixed_lat = 0;
        request(0, rand_cmd());
        wait_idle();

        // stale i_done held high while idle
        stale_hold = 1;
        repeat (3) step();
        fixed_lat = 3;
        request(1, rand_cmd());
        wait_idle();
        stale_hold = 0;
        step();

        // reset during WAIT, then a late i_done
        fixed_lat = -1;
        request(0, rand_cmd());
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        stale_hold = 1;
        repeat (3) step();
        stale_hold = 0;
        step();

        // contention from reset: both requesters valid continuously
        do_reset();
        fixed_lat = 0;
        cmd0 = rand_cmd(); cmd1 = rand_cmd(); valid = 2'b11; n_acc = 0;
        for (int i = 0; i < 200 && n_acc < 6; i++) begin
            @(negedge clk); acc = o_ready;
            step();
            if (acc[0]) begin cmd0 = rand_cmd(); n_acc++; end
            if (acc[1]) begin cmd1 = rand_cmd(); n_acc++; end
        end
        chk("contention_accepts", n_acc, 6);
        valid[0] = 1'b0;
        acc = 2'b00;
        for (int i = 0; i < 100 && !acc[1]; i++) begin
            @(negedge clk); acc = o_ready;
            step();
        end
        chk("req1_after_drop", acc[1], 1'b1);
        valid = 2'b00;
        wait_idle();

        // randomized traffic with random LDA latency and withdrawals
        rand_lat = 1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); acc = o_ready;
            step();
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) begin
                    if ($urandom_range(0, 1) == 0) valid[k] = 1'b0;
                    else if (k == 0) cmd0 = rand_cmd();
                    else cmd1 = rand_cmd();
                end else if (valid[k]) begin
                    if ($urandom_range(0, 19) == 0) valid[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if (k == 0) cmd0 = rand_cmd(); else cmd1 = rand_cmd();
                    valid[k] = 1'b1;
                end
            end
        end
        valid = 2'b00;
        wait_idle();
        repeat (3) step();
        chk("queue_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
